// File: rtl/dio_pkg.sv
// dio_pkg: shared FSM state type and index mapping constant for dio_router.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dio_pkg;

  // Download sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dio_state_t;

  // Download index k+IDX_OFFSET selects channel k (index 0 means "no target").
  localparam int unsigned IDX_OFFSET = 1;

endpackage

// File: rtl/dio_fifo.sv
// dio_fifo: DEPTH-entry write buffer with extra-bit pointers for full/empty.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module dio_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_pop_dat,
  output logic         o_empty,
  output logic         o_push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [PW:0]  r_wptr;
  logic [PW:0]  r_rptr;
  logic [W-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_pop_ok;

  // Same low bits with differing wrap bit means the writer is a full lap ahead.
  assign o_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // A pop frees the slot this cycle, so a push onto a full buffer still fits.
  assign o_push_ok = i_push && (!w_full || w_pop_ok);
  assign o_pop_dat = r_mem[r_rptr[PW-1:0]];

  // Pointer update; reset flushes the buffer by collapsing both pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (o_push_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (o_push_ok) r_mem[r_wptr[PW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/dio_router.sv
// dio_router: routes a loader download to one of CHANNELS targets via a write buffer.
// Latency: a strobed byte is buffered one cycle later and offered on memV the cycle after.
// Backpressure: memR stalls the buffer head; strobes arriving while full are dropped and set ovf.
// Optional: define DIO_ROUTER_CHECKSUM_EN to enable the running byte checksum on sum.
module dio_router
  import dio_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int AW       = 27,
  parameter int DEPTH    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dioE,
  input  logic [7:0]          dioI,
  input  logic [AW-1:0]       dioA,
  input  logic [7:0]          dioD,
  input  logic                dioW,
  input  logic [31:0]         dioS,
  output logic [CHANNELS-1:0] chE,
  output logic [CHANNELS-1:0] chDone,
  output logic [AW-1:0]       memA,
  output logic [7:0]          memD,
  output logic                memV,
  input  logic                memR,
  output logic [31:0]         size,
  output logic                ovf,
  output logic [7:0]          sum
);

  localparam logic [7:0] IDX_LO = 8'(IDX_OFFSET);
  localparam logic [7:0] IDX_HI = 8'(CHANNELS);

  dio_state_t          r_state;
  logic                r_dioE_d;
  logic                r_wr_vld;
  logic [AW+7:0]       r_wr_dat;
  logic [CHANNELS-1:0] r_chE;
  logic [CHANNELS-1:0] r_chDone;
  logic [31:0]         r_size;
  logic                r_ovf;

  logic                w_rise;
  logic                w_fall;
  logic                w_idx_ok;
  logic                w_start;
  logic [CHANNELS-1:0] w_onehot;
  logic                w_empty;
  logic                w_push_ok;
  logic [AW+7:0]       w_head;

  assign w_rise    = dioE && !r_dioE_d;
  assign w_fall    = !dioE && r_dioE_d;
  assign w_idx_ok  = (dioI >= IDX_LO) && (dioI <= IDX_HI);
  assign w_onehot  = CHANNELS'(1) << (dioI - IDX_LO);
  assign w_start   = (r_state == ST_IDLE) && w_rise && w_idx_ok;

  assign chE    = r_chE;
  assign chDone = r_chDone;
  assign size   = r_size;
  assign ovf    = r_ovf;
  assign memV   = !w_empty;
  assign memA   = w_head[AW+7:8];
  assign memD   = w_head[7:0];

  // Edge detector tracks dioE even in reset, so a loader holding dioE high
  // across a reset does not look like a fresh download start afterwards.
  always_ff @(posedge clock) begin
    r_dioE_d <= dioE;
  end

  // Strobe capture stage: only strobes seen during LOAD enter the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_vld <= 1'b0;
      r_wr_dat <= '0;
    end else begin
      r_wr_vld <= (r_state == ST_LOAD) && dioW;
      r_wr_dat <= {dioA, dioD};
    end
  end

  dio_fifo #(
    .W     (AW + 8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (r_wr_vld),
    .i_push_dat (r_wr_dat),
    .i_pop      (memR),
    .o_pop_dat  (w_head),
    .o_empty    (w_empty),
    .o_push_ok  (w_push_ok)
  );

  // Download sequencer with registered channel, completion, size and overflow outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_chE    <= '0;
      r_chDone <= '0;
      r_size   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_chDone <= '0;
      if (r_wr_vld && !w_push_ok) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_LOAD;
            r_chE   <= w_onehot;
            r_size  <= dioS;
            r_ovf   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_fall) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // The capture stage may still hold the final byte, so wait for it too.
          if (w_empty && !r_wr_vld) begin
            r_state  <= ST_DONE;
            r_chDone <= r_chE;
            r_chE    <= '0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DIO_ROUTER_CHECKSUM_EN
  logic [7:0] r_sum;

  // Running checksum of bytes actually accepted into the buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum <= 8'd0;
    end else if (w_start) begin
      r_sum <= 8'd0;
    end else if (w_push_ok) begin
      r_sum <= r_sum + r_wr_dat[7:0];
    end
  end

  assign sum = r_sum;
`else
  assign sum = 8'd0;
`endif

endmodule
